// File: rtl/mgnt_pkg.sv
// mgnt_pkg: shared magnet-sequencer types, channel-index sizing and next-enabled-channel priority pick
package mgnt_pkg;
  typedef enum logic [2:0] {IDLE, CHG, CHG_DLY, DCHG, DCHG_DLY, POST} state_t;
  localparam int NCH_MAX = 16;
  localparam int CH_IDX_W = $clog2(NCH_MAX);
  typedef struct packed {
    logic                found;
    logic [CH_IDX_W-1:0] idx;
  } ch_sel_t;
  function automatic int ch_idx_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction
  // lowest set bit of mask at or above index from; found=0 when none remain
  function automatic ch_sel_t next_enabled(input logic [NCH_MAX-1:0] mask, input logic [CH_IDX_W:0] from);
    next_enabled = '0;
    for (int i = NCH_MAX - 1; i >= 0; i--)
      if (mask[i] && (5'(i) >= from)) next_enabled = {1'b1, 4'(i)};
  endfunction
endpackage

// File: rtl/mgnt_pulse_timer.sv
// mgnt_pulse_timer: loadable down-counter; a load of length L expires after L cycles, L=0 behaves as 1
module mgnt_pulse_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;
  // load length-1 (zero lengths bypass to an immediate expire), otherwise count down to 0 and hold
  always_comb begin
    cnt_d = load ? ((len == '0) ? '0 : len - W'(1)) : ((cnt_q == '0) ? '0 : cnt_q - W'(1));
  end
  assign expired = (cnt_q == '0);
  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mgnt_multich_controller.sv
// mgnt_multich_controller: multi-channel magnet CHG/DCHG sequencer; MGNT_ABORT_EN adds the ABORT port
module mgnt_multich_controller
  import mgnt_pkg::*;
#(
  parameter int DATABUS_WIDTH = 32,
  parameter int NCH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic [NCH-1:0]           CH_EN,
  input  logic [DATABUS_WIDTH-1:0] CHG_PLEN,
  input  logic [DATABUS_WIDTH-1:0] CHG_DLEN,
  input  logic [DATABUS_WIDTH-1:0] DCHG_PLEN,
  input  logic [DATABUS_WIDTH-1:0] DCHG_DLEN,
  input  logic [DATABUS_WIDTH-1:0] N,
  input  logic [DATABUS_WIDTH-1:0] D,
`ifdef MGNT_ABORT_EN
  input  logic                     ABORT,
`endif
  output logic                     FSMSTAT,
  output logic                     DONE,
  output logic [DATABUS_WIDTH-1:0] REP_CNT,
  output logic [NCH-1:0]           CHG_OUT,
  output logic [NCH-1:0]           DCHG_OUT
);
  localparam int W = DATABUS_WIDTH;
  localparam int CW = ch_idx_width(NCH);
  state_t         state_q, state_d, s_dd, s_dp, s_cd, entry, after, post_st;
  logic [CW-1:0]  ch_q, ch_d;
  logic [W-1:0]   rep_q, rep_d, rep_inc, load_len;
  logic [W-1:0]   cp_q, cp_d, cd_q, cd_d, dp_q, dp_d, dd_q, dd_d, n_q, n_d, d_q, d_d;
  logic [W-1:0]   l_cp, l_cd, l_dp, l_dd, l_n, l_d;
  logic [NCH-1:0] en_q, en_d, l_en, chg_q, chg_d, dchg_q, dchg_d;
  logic           start_q, fsm_q, fsm_d, done_q, done_d;
  logic           idle, go, abort, abort_req, adv, expired;
  ch_sel_t        nxt, first;
`ifdef MGNT_ABORT_EN
  assign abort_req = ABORT;
`else
  assign abort_req = 1'b0;
`endif
  mgnt_pulse_timer #(.W(W)) u_timer (
    .clk     (CLK),
    .rst     (RESET),
    .load    (adv),
    .len     (load_len),
    .expired (expired)
  );
  // next-state: zero-length states are skipped combinationally so visits chain without gap cycles
  always_comb begin
    idle     = (state_q == IDLE);
    abort    = abort_req & ~idle;
    go       = idle & START & ~start_q & ~abort_req;
    l_cp     = idle ? CHG_PLEN : cp_q;
    l_cd     = idle ? CHG_DLEN : cd_q;
    l_dp     = idle ? DCHG_PLEN : dp_q;
    l_dd     = idle ? DCHG_DLEN : dd_q;
    l_n      = idle ? N : n_q;
    l_d      = idle ? D : d_q;
    l_en     = idle ? CH_EN : en_q;
    nxt      = next_enabled(NCH_MAX'(l_en), 5'(ch_q) + 5'd1);
    first    = next_enabled(NCH_MAX'(l_en), 5'd0);
    rep_inc  = (&rep_q) ? rep_q : rep_q + W'(1);
    post_st  = (l_d != '0) ? POST : IDLE;
    s_dd     = (l_dd != '0) ? DCHG_DLY : IDLE;
    s_dp     = (l_dp != '0) ? DCHG : s_dd;
    s_cd     = (l_cd != '0) ? CHG_DLY : s_dp;
    entry    = (l_cp != '0) ? CHG : (s_cd == IDLE) ? DCHG_DLY : s_cd;
    after    = (state_q == CHG) ? s_cd : (state_q == CHG_DLY) ? s_dp : (state_q == DCHG) ? s_dd : IDLE;
    state_d  = state_q;
    ch_d     = ch_q;
    rep_d    = rep_q;
    adv      = 1'b0;
    if (abort) state_d = IDLE;
    else if (go) begin
      adv   = 1'b1;
      rep_d = '0;
      ch_d  = CW'(first.idx);
      state_d = ((l_n == '0) || !first.found) ? post_st : entry;
    end else if (!idle && expired) begin
      adv = 1'b1;
      if (state_q == POST) state_d = IDLE;
      else if (after != IDLE) state_d = after;
      else if (nxt.found) begin
        ch_d    = CW'(nxt.idx);
        state_d = entry;
      end else begin
        rep_d   = rep_inc;
        ch_d    = CW'(first.idx);
        state_d = (rep_inc == l_n) ? post_st : entry;
      end
    end
    load_len = (state_d == CHG) ? l_cp : (state_d == CHG_DLY) ? l_cd : (state_d == DCHG) ? l_dp :
               (state_d == DCHG_DLY) ? l_dd : l_d;
    chg_d    = (state_d == CHG) ? NCH'(1) << ch_d : '0;
    dchg_d   = (state_d == DCHG) ? NCH'(1) << ch_d : '0;
    fsm_d    = (state_d != IDLE);
    done_d   = (state_d == IDLE) & (~idle | go);
    cp_d     = go ? CHG_PLEN : cp_q;
    cd_d     = go ? CHG_DLEN : cd_q;
    dp_d     = go ? DCHG_PLEN : dp_q;
    dd_d     = go ? DCHG_DLEN : dd_q;
    n_d      = go ? N : n_q;
    d_d      = go ? D : d_q;
    en_d     = go ? CH_EN : en_q;
  end
  // state, latched parameters and registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      ch_q    <= '0;
      rep_q   <= '0;
      start_q <= 1'b0;
      fsm_q   <= 1'b0;
      done_q  <= 1'b0;
      chg_q   <= '0;
      dchg_q  <= '0;
      cp_q    <= '0;
      cd_q    <= '0;
      dp_q    <= '0;
      dd_q    <= '0;
      n_q     <= '0;
      d_q     <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      rep_q   <= rep_d;
      start_q <= START;
      fsm_q   <= fsm_d;
      done_q  <= done_d;
      chg_q   <= chg_d;
      dchg_q  <= dchg_d;
      cp_q    <= cp_d;
      cd_q    <= cd_d;
      dp_q    <= dp_d;
      dd_q    <= dd_d;
      n_q     <= n_d;
      d_q     <= d_d;
      en_q    <= en_d;
    end
  end
  assign FSMSTAT  = fsm_q;
  assign DONE     = done_q;
  assign REP_CNT  = rep_q;
  assign CHG_OUT  = chg_q;
  assign DCHG_OUT = dchg_q;
endmodule

// File: tb/tb_mgnt_multich_controller.sv
// tb_mgnt_multich_controller: directed scoreboard bench for the multi-channel magnet sequencer
module tb_mgnt_multich_controller;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0] ch_en = '0, chg_out, dchg_out;
  logic [W-1:0] cp = '0, cd = '0, dp = '0, dd = '0, n = '0, d = '0, rep_cnt;
  logic fsmstat, done;
  int n_cmp = 0, n_err = 0;
  logic [9:0] exp_q[$];
  logic [W-1:0] exp_rep;

  always #5 clk = ~clk;

  mgnt_multich_controller #(.DATABUS_WIDTH(W), .NCH(4)) dut (
    .CLK(clk), .RESET(rst), .START(start), .CH_EN(ch_en),
    .CHG_PLEN(cp), .CHG_DLEN(cd), .DCHG_PLEN(dp), .DCHG_DLEN(dd), .N(n), .D(d),
`ifdef MGNT_ABORT_EN
    .ABORT(abort),
`endif
    .FSMSTAT(fsmstat), .DONE(done), .REP_CNT(rep_cnt), .CHG_OUT(chg_out), .DCHG_OUT(dchg_out)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cfg(input logic [3:0] e, input int a, input int b, input int c, input int f, input int r, input int p);
    ch_en = e; cp = W'(a); cd = W'(b); dp = W'(c); dd = W'(f); n = W'(r); d = W'(p);
  endtask

  // expected per-cycle {FSMSTAT, DONE, CHG_OUT, DCHG_OUT} timeline for one run
  task automatic build();
    logic [3:0] oh;
    exp_rep = (ch_en == 0) ? '0 : n;
    if (n != 0 && ch_en != 0)
      for (int r = 0; r < int'(n); r++)
        for (int c = 0; c < 4; c++)
          if (ch_en[c]) begin
            oh = 4'b0001 << c;
            if (cp == 0 && cd == 0 && dp == 0 && dd == 0) exp_q.push_back(10'b10_0000_0000);
            for (int j = 0; j < int'(cp); j++) exp_q.push_back({2'b10, oh, 4'b0000});
            for (int j = 0; j < int'(cd); j++) exp_q.push_back(10'b10_0000_0000);
            for (int j = 0; j < int'(dp); j++) exp_q.push_back({2'b10, 4'b0000, oh});
            for (int j = 0; j < int'(dd); j++) exp_q.push_back(10'b10_0000_0000);
          end
    for (int j = 0; j < int'(d); j++) exp_q.push_back(10'b10_0000_0000);
    exp_q.push_back(10'b01_0000_0000);
    exp_q.push_back(10'b00_0000_0000);
  endtask

  // start at the next edge, then pop one expectation per cycle; limit>=0 stops early at that index
  task automatic run(input string tag, input bit hold, input bit scramble, input int limit);
    logic [9:0] e;
    build();
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d]", tag, i), W'({fsmstat, done, chg_out, dchg_out}), W'(e));
      if (i == 0) chk($sformatf("%s_rep_clr", tag), rep_cnt, '0);
      if (e[8]) chk($sformatf("%s_rep_end", tag), rep_cnt, exp_rep);
      if (i == limit) begin
        exp_q.delete();
        break;
      end
      if (scramble && i == 1) begin
        ch_en = 4'($urandom);
        cp = W'($urandom_range(1, 9)); cd = W'($urandom_range(1, 9)); dp = W'($urandom_range(1, 9));
        dd = W'($urandom_range(1, 9)); n = W'($urandom_range(1, 9)); d = W'($urandom_range(1, 9));
      end
      start = hold ? ((i < 9) || (i >= 19 && i < 22)) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_fsm", W'(fsmstat), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_rep", rep_cnt, '0);
    chk("rst_chg", W'(chg_out), '0);
    chk("rst_dchg", W'(dchg_out), '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    cfg(4'b0101, 3, 4, 5, 6, 2, 50);
    run("base", 0, 0, -1);
    run("hold", 1, 0, -1);
    repeat (5) @(negedge clk);
    chk("hold_no_retrig", W'({fsmstat, done, chg_out, dchg_out}), '0);
    cfg(4'b0101, 3, 4, 5, 6, 2, 50);
    run("rerun", 0, 1, -1);

    cfg(4'b0011, 2, 0, 3, 0, 1, 3);
    run("contig", 0, 0, -1);
    cfg(4'b0101, 3, 4, 5, 6, 0, 7);
    run("n0", 0, 0, -1);
    cfg(4'b0000, 3, 4, 5, 6, 2, 7);
    run("en0", 0, 0, -1);
    cfg(4'b0101, 0, 0, 0, 0, 2, 4);
    run("zero", 0, 0, -1);

    cfg(4'b0101, 3, 4, 5, 6, 2, 50);
    run("pre_rst", 0, 0, 9);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_dchg", W'(dchg_out), '0);
    chk("rst_async_fsm", W'(fsmstat), '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run("post_rst", 0, 0, -1);

`ifdef MGNT_ABORT_EN
    cfg(4'b0101, 3, 4, 5, 6, 2, 50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_c0", W'({fsmstat, done, chg_out, dchg_out}), W'(10'b10_0001_0000));
    @(negedge clk);
    chk("abort_c1", W'({fsmstat, done, chg_out, dchg_out}), W'(10'b10_0001_0000));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_end", W'({fsmstat, done, chg_out, dchg_out}), W'(10'b01_0000_0000));
    chk("abort_rep", rep_cnt, '0);
    repeat (3) @(negedge clk);
    chk("abort_no_post", W'({fsmstat, done, chg_out, dchg_out}), '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
